// File: rtl/qed_dup_scheduler.sv
// QED burst sequencer: counts original fetches, replays the same number as
// duplicates, then raises a one-cycle consistency-check strobe.
module qed_dup_scheduler #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             fetch_vld,
  input  logic             stall_IF,
  input  logic             switch_req,
  output logic             exec_dup,
  output logic             qed_check,
  output logic             busy,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] orig_cnt,
  output logic [CNT_W-1:0] dup_cnt,
  output logic             ovf_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ORIG  = 2'd1,
    DUP   = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C  = '0;

  // Handshake: an instruction is consumed (fire) only when fetch_vld is high
  // and stall_IF is low in the same cycle; nothing else advances the counters.
  logic fire;
  assign fire = fetch_vld & ~stall_IF;

  state_t           cur, nxt;
  logic [CNT_W-1:0] orig_nxt, dup_nxt;
  logic             ovf_nxt;

  assign state = cur;

  always_comb begin
    nxt      = cur;
    orig_nxt = orig_cnt;
    dup_nxt  = dup_cnt;
    ovf_nxt  = ovf_err;
    case (cur)
      IDLE: begin
        orig_nxt = ZERO_C;
        dup_nxt  = ZERO_C;
        if (ena) nxt = ORIG;
      end
      ORIG: begin
        if (fire) begin
          if (orig_cnt == DEPTH_C) ovf_nxt = 1'b1;
          else                     orig_nxt = orig_cnt + ONE_C;
        end
        // Decisions use the post-update count so a same-cycle fire counts.
        if ((fire && orig_nxt == DEPTH_C) ||
            ((switch_req || !ena) && orig_nxt != ZERO_C))
          nxt = DUP;
        else if (!ena)
          nxt = IDLE;
      end
      DUP: begin
        if (fire) begin
          dup_nxt = dup_cnt + ONE_C;
          if (dup_nxt == orig_cnt) nxt = CHECK;
        end
      end
      CHECK: begin
        orig_nxt = ZERO_C;
        dup_nxt  = ZERO_C;
        nxt      = ena ? ORIG : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= IDLE;
      exec_dup  <= 1'b0;
      qed_check <= 1'b0;
      busy      <= 1'b0;
      orig_cnt  <= ZERO_C;
      dup_cnt   <= ZERO_C;
      ovf_err   <= 1'b0;
    end else begin
      cur       <= nxt;
      exec_dup  <= (nxt == DUP);
      qed_check <= (nxt == CHECK);
      busy      <= (nxt != IDLE);
      orig_cnt  <= orig_nxt;
      dup_cnt   <= dup_nxt;
      ovf_err   <= ovf_nxt;
    end
  end

endmodule
